// File: rtl/issue_control.sv
// issue_control: single-entry issue stage between decode and the functional units.
// Checks RAW hazards against the register scoreboard, blocks on a busy divider,
// optionally bypasses from the final execute stage and claims the destination on issue.
// Optional feature: define ISSUE_BYPASS_EN to allow bypass from scoreboard row 5'b00001.
module issue_control #(
   parameter int unsigned DIV_CYCLES  = 8,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4:0]             in_rs,
   input  logic [4:0]             in_rt,
   input  logic [4:0]             in_rd,
   input  logic [1:0]             in_unit,
   input  logic                   in_uses_rs,
   input  logic                   in_uses_rt,
   input  logic                   in_writes_rd,
   input  logic                   flush,
   output logic [4:0]             ass_addr_a,
   output logic [4:0]             ass_addr_b,
   input  logic                   ass_pending_a,
   input  logic                   ass_pending_b,
   input  logic [1:0]             ass_unit_a,
   input  logic [1:0]             ass_unit_b,
   input  logic [4:0]             ass_row_a,
   input  logic [4:0]             ass_row_b,
   output logic [4:0]             writeaddr,
   output logic [1:0]             registerunit,
   output logic                   enablewrite,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   output logic [4:0]             issue_rs,
   output logic [4:0]             issue_rt,
   output logic [4:0]             issue_rd,
   output logic [1:0]             issue_unit,
   output logic [2:0]             issue_fwd_a,
   output logic [2:0]             issue_fwd_b,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned UNIT_W = 2;
   localparam int unsigned FWD_W  = 3;
   localparam int unsigned DIV_W  = 5;
   localparam logic [UNIT_W-1:0] DIV_UNIT  = UNIT_W'(3);
   localparam logic [4:0]        FINAL_ROW = 5'b00001;
`ifdef ISSUE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   typedef struct packed {
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [UNIT_W-1:0] unit;
      logic              uses_rs;
      logic              uses_rt;
      logic              writes_rd;
   } instr_t;

   instr_t            hold_q;
   logic              hold_valid;
   logic [DIV_W-1:0]  div_cnt;
   logic              haz_a;
   logic              haz_b;
   logic [FWD_W-1:0]  fwd_a;
   logic [FWD_W-1:0]  fwd_b;
   logic              struct_haz;
   logic              fire;

   // Operand source selection and RAW hazard detection for both sources
   always_comb begin
      haz_a = 1'b0;
      haz_b = 1'b0;
      fwd_a = '0;
      fwd_b = '0;
      if (hold_q.uses_rs && (hold_q.rs != '0) && ass_pending_a) begin
         if (BYPASS_EN && (ass_row_a == FINAL_ROW)) fwd_a = {1'b1, ass_unit_a};
         else                                       haz_a = 1'b1;
      end
      if (hold_q.uses_rt && (hold_q.rt != '0) && ass_pending_b) begin
         if (BYPASS_EN && (ass_row_b == FINAL_ROW)) fwd_b = {1'b1, ass_unit_b};
         else                                       haz_b = 1'b1;
      end
   end

   assign struct_haz   = (hold_q.unit == DIV_UNIT) && (div_cnt != '0);
   assign issue_valid  = hold_valid & ~flush & ~haz_a & ~haz_b & ~struct_haz;
   assign fire         = issue_valid & issue_ready;
   assign in_ready     = (~hold_valid | fire) & ~flush;

   assign ass_addr_a   = hold_q.rs;
   assign ass_addr_b   = hold_q.rt;
   assign issue_rs     = hold_q.rs;
   assign issue_rt     = hold_q.rt;
   assign issue_rd     = hold_q.rd;
   assign issue_unit   = hold_q.unit;
   assign issue_fwd_a  = fwd_a;
   assign issue_fwd_b  = fwd_b;

   assign enablewrite  = fire & hold_q.writes_rd & (hold_q.rd != '0);
   assign writeaddr    = enablewrite ? hold_q.rd   : '0;
   assign registerunit = enablewrite ? hold_q.unit : '0;

   // Hold register: flush drops, accept loads, issue empties
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_valid <= 1'b0;
         hold_q     <= '0;
      end else if (flush) begin
         hold_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         hold_valid       <= 1'b1;
         hold_q.rs        <= in_rs;
         hold_q.rt        <= in_rt;
         hold_q.rd        <= in_rd;
         hold_q.unit      <= in_unit;
         hold_q.uses_rs   <= in_uses_rs;
         hold_q.uses_rt   <= in_uses_rt;
         hold_q.writes_rd <= in_writes_rd;
      end else if (fire) begin
         hold_valid <= 1'b0;
      end
   end

   // Divider occupancy: reload on divider issue, otherwise count down to idle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (fire && (hold_q.unit == DIV_UNIT)) begin
         div_cnt <= DIV_W'(DIV_CYCLES - 1);
      end else if (div_cnt != '0) begin
         div_cnt <= div_cnt - DIV_W'(1);
      end
   end

   // Saturating count of cycles where a held instruction could not issue
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (hold_valid && !issue_valid && !flush && (stall_count != '1)) begin
         stall_count <= stall_count + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_issue_control.sv
// tb_issue_control: directed steps followed by random traffic, checked against a
// cycle-indexed behavioural model of the issue stage.
module tb_issue_control;

   localparam int unsigned SW       = 6;
   localparam int unsigned DIVC     = 8;
   localparam int          SMAX     = (1 << SW) - 1;
`ifdef ISSUE_BYPASS_EN
   localparam bit          BYP      = 1'b1;
`else
   localparam bit          BYP      = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_rs, in_rt, in_rd;
   logic [1:0]    in_unit;
   logic          in_uses_rs, in_uses_rt, in_writes_rd;
   logic          flush;
   logic [4:0]    ass_addr_a, ass_addr_b;
   logic          ass_pending_a, ass_pending_b;
   logic [1:0]    ass_unit_a, ass_unit_b;
   logic [4:0]    ass_row_a, ass_row_b;
   logic [4:0]    writeaddr;
   logic [1:0]    registerunit;
   logic          enablewrite;
   logic          issue_valid;
   logic          issue_ready;
   logic [4:0]    issue_rs, issue_rt, issue_rd;
   logic [1:0]    issue_unit;
   logic [2:0]    issue_fwd_a, issue_fwd_b;
   logic [SW-1:0] stall_count;

   issue_control #(.DIV_CYCLES(DIVC), .STALL_CNT_W(SW)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_unit(in_unit),
      .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_writes_rd(in_writes_rd),
      .flush(flush),
      .ass_addr_a(ass_addr_a), .ass_addr_b(ass_addr_b),
      .ass_pending_a(ass_pending_a), .ass_pending_b(ass_pending_b),
      .ass_unit_a(ass_unit_a), .ass_unit_b(ass_unit_b),
      .ass_row_a(ass_row_a), .ass_row_b(ass_row_b),
      .writeaddr(writeaddr), .registerunit(registerunit), .enablewrite(enablewrite),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_unit(issue_unit),
      .issue_fwd_a(issue_fwd_a), .issue_fwd_b(issue_fwd_b),
      .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0] rs, rt, rd;
      logic [1:0] unit;
      logic       urs, urt, wrd;
   } instr_t;

   // reference model state: held instruction, absolute cycle the divider frees up
   instr_t m_h;
   logic   m_hv;
   int     m_stall;
   int     cyc;
   int     div_free;

   logic       e_iv, e_fire, e_in_ready, e_ew;
   logic [4:0] e_wa;
   logic [1:0] e_ru;
   logic [2:0] e_fwd_a, e_fwd_b;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // returns {hazard, fwd[2:0]} for one source operand
   function automatic logic [3:0] opnd(input logic uses, input logic [4:0] r, input logic pend,
                                       input logic [1:0] u, input logic [4:0] row);
      if (!uses || r == 5'd0 || !pend) return 4'b0000;
      if (BYP && row == 5'b00001) return {2'b01, u};
      return 4'b1000;
   endfunction

   function automatic void compute_expected();
      logic [3:0] oa, ob;
      logic       div_busy;
      oa       = opnd(m_h.urs, m_h.rs, ass_pending_a, ass_unit_a, ass_row_a);
      ob       = opnd(m_h.urt, m_h.rt, ass_pending_b, ass_unit_b, ass_row_b);
      div_busy = (m_h.unit == 2'd3) && (cyc < div_free);
      e_iv       = m_hv && !flush && !oa[3] && !ob[3] && !div_busy;
      e_fire     = e_iv && issue_ready;
      e_in_ready = (!m_hv || e_fire) && !flush;
      e_ew       = e_fire && m_h.wrd && (m_h.rd != 5'd0);
      e_wa       = e_ew ? m_h.rd : 5'd0;
      e_ru       = e_ew ? m_h.unit : 2'd0;
      e_fwd_a    = oa[2:0];
      e_fwd_b    = ob[2:0];
   endfunction

   task automatic model_reset();
      m_hv     = 1'b0;
      m_h      = '{5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      m_stall  = 0;
      div_free = cyc;
   endtask

   task automatic settle();
      #1;
      compute_expected();
      chk("in_ready",     32'(in_ready),     32'(e_in_ready));
      chk("issue_valid",  32'(issue_valid),  32'(e_iv));
      chk("enablewrite",  32'(enablewrite),  32'(e_ew));
      chk("writeaddr",    32'(writeaddr),    32'(e_wa));
      chk("registerunit", 32'(registerunit), 32'(e_ru));
      chk("stall_count",  32'(stall_count),  32'(m_stall));
      if (m_hv) begin
         chk("ass_addr_a",  32'(ass_addr_a),  32'(m_h.rs));
         chk("ass_addr_b",  32'(ass_addr_b),  32'(m_h.rt));
         chk("issue_rs",    32'(issue_rs),    32'(m_h.rs));
         chk("issue_rt",    32'(issue_rt),    32'(m_h.rt));
         chk("issue_rd",    32'(issue_rd),    32'(m_h.rd));
         chk("issue_unit",  32'(issue_unit),  32'(m_h.unit));
         chk("issue_fwd_a", 32'(issue_fwd_a), 32'(e_fwd_a));
         chk("issue_fwd_b", 32'(issue_fwd_b), 32'(e_fwd_b));
      end
   endtask

   task automatic advance();
      compute_expected();
      @(posedge clock);
      if (m_hv && !e_iv && !flush && m_stall < SMAX) m_stall++;
      if (e_fire && m_h.unit == 2'd3) div_free = cyc + DIVC;
      if (flush) m_hv = 1'b0;
      else if (in_valid && e_in_ready) begin
         m_hv = 1'b1;
         m_h  = '{in_rs, in_rt, in_rd, in_unit, in_uses_rs, in_uses_rt, in_writes_rd};
      end else if (e_fire) m_hv = 1'b0;
      cyc++;
      @(negedge clock);
   endtask

   task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [1:0] unit,
                            input logic urs, input logic urt, input logic wrd);
      in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; in_unit = unit;
      in_uses_rs = urs; in_uses_rt = urt; in_writes_rd = wrd;
   endtask

   task automatic set_sb(input logic pa, input logic [1:0] ua, input logic [4:0] ra,
                         input logic pb, input logic [1:0] ub, input logic [4:0] rb);
      ass_pending_a = pa; ass_unit_a = ua; ass_row_a = ra;
      ass_pending_b = pb; ass_unit_b = ub; ass_row_b = rb;
   endtask

   function automatic logic [4:0] rand_row();
      logic [4:0] r;
      r = 5'd1 << $urandom_range(4, 0);
      return r;
   endfunction

   initial begin
      cyc = 0;
      reset = 1'b1;
      flush = 1'b0;
      issue_ready = 1'b1;
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      set_sb(0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clock);

      // reset state
      settle();
      chk("rst_in_ready",    32'(in_ready),    32'd1);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_issue_rd",    32'(issue_rd),    32'd0);
      chk("rst_issue_unit",  32'(issue_unit),  32'd0);
      chk("rst_fwd_a",       32'(issue_fwd_a), 32'd0);
      chk("rst_stall",       32'(stall_count), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // basic issue one cycle after acceptance, claim r3 for unit 0
      set_instr(1, 5'd1, 5'd2, 5'd3, 2'd0, 1, 1, 1);
      settle(); chk("t1_accept", 32'(in_ready), 32'd1); advance();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      chk("t1_fire",  32'(issue_valid), 32'd1);
      chk("t1_ew",    32'(enablewrite), 32'd1);
      chk("t1_waddr", 32'(writeaddr),   32'd3);
      chk("t1_unit",  32'(registerunit), 32'd0);
      advance();

      // RAW stall on r5 walking down the execute rows
      set_instr(1, 5'd5, 5'd0, 5'd6, 2'd1, 1, 0, 1);
      settle(); advance();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 4; i >= 1; i--) begin
         set_sb(1, 2'd2, 5'(1 << i), 0, 0, 0);
         settle(); chk("t2_stall", 32'(issue_valid), 32'd0); advance();
      end
      set_sb(1, 2'd2, 5'b00001, 0, 0, 0);
      settle();
      chk("t2_stall_cnt", 32'(stall_count), 32'd4);
      if (BYP) begin
         chk("t2_byp_issue", 32'(issue_valid), 32'd1);
         chk("t2_byp_fwd",   32'(issue_fwd_a), 32'b110);
         advance();
      end else begin
         chk("t2_nobyp_stall", 32'(issue_valid), 32'd0);
         advance();
         set_sb(0, 0, 0, 0, 0, 0);
         settle();
         chk("t2_nobyp_issue", 32'(issue_valid), 32'd1);
         chk("t2_nobyp_fwd",   32'(issue_fwd_a), 32'd0);
         advance();
      end
      set_sb(0, 0, 0, 0, 0, 0);

      // divider occupancy; unit-0 op slips in behind the first divide
      set_instr(1, 5'd1, 5'd2, 5'd7, 2'd3, 1, 1, 1);
      settle(); advance();
      set_instr(1, 5'd3, 5'd4, 5'd8, 2'd0, 1, 1, 1);
      settle();
      chk("t3_div1_fire", 32'(issue_valid), 32'd1);
      chk("t3_div1_ru",   32'(registerunit), 32'd3);
      advance();
      set_instr(1, 5'd9, 5'd10, 5'd11, 2'd3, 1, 1, 1);
      settle();
      chk("t3_u0_fire", 32'(issue_valid), 32'd1);
      chk("t3_u0_unit", 32'(issue_unit),  32'd0);
      advance();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 2; k < 8; k++) begin
         settle(); chk("t3_div2_wait", 32'(issue_valid), 32'd0); advance();
      end
      settle();
      chk("t3_div2_fire", 32'(issue_valid), 32'd1);
      chk("t3_div2_unit", 32'(issue_unit),  32'd3);
      advance();

      // r0 as source and destination never stalls nor claims
      set_instr(1, 5'd0, 5'd0, 5'd0, 2'd2, 1, 1, 1);
      settle(); advance();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      set_sb(1, 2'd1, 5'b10000, 1, 2'd1, 5'b10000);
      settle();
      chk("t4_issue", 32'(issue_valid), 32'd1);
      chk("t4_ew",    32'(enablewrite), 32'd0);
      advance();
      set_sb(0, 0, 0, 0, 0, 0);

      // back-pressure from the units
      set_instr(1, 5'd1, 5'd2, 5'd4, 2'd1, 1, 1, 1);
      settle(); advance();
      set_instr(1, 5'd12, 5'd13, 5'd14, 2'd2, 1, 1, 1);
      issue_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("t5_hold_iv", 32'(issue_valid), 32'd1);
         chk("t5_no_ew",   32'(enablewrite), 32'd0);
         chk("t5_inrdy",   32'(in_ready),    32'd0);
         chk("t5_rd",      32'(issue_rd),    32'd4);
         advance();
      end
      issue_ready = 1'b1;
      settle(); chk("t5_release", 32'(enablewrite), 32'd1); advance();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      settle(); advance();

      // flush during a stall while decode offers another instruction
      set_instr(1, 5'd5, 5'd0, 5'd15, 2'd1, 1, 0, 1);
      set_sb(1, 2'd0, 5'b10000, 0, 0, 0);
      settle(); advance();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      settle(); chk("t6_stalled", 32'(issue_valid), 32'd0); advance();
      set_instr(1, 5'd1, 5'd1, 5'd16, 2'd0, 1, 1, 1);
      flush = 1'b1;
      settle();
      chk("t6_flush_inrdy", 32'(in_ready),    32'd0);
      chk("t6_flush_iv",    32'(issue_valid), 32'd0);
      advance();
      flush = 1'b0;
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      chk("t6_empty_inrdy", 32'(in_ready),    32'd1);
      chk("t6_empty_iv",    32'(issue_valid), 32'd0);
      advance();

      // reset in the middle of a stall
      set_instr(1, 5'd5, 5'd0, 5'd17, 2'd2, 1, 0, 1);
      settle(); advance();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      settle(); advance();
      reset = 1'b1;
      model_reset();
      settle();
      chk("t7_rst_iv",    32'(issue_valid), 32'd0);
      chk("t7_rst_ew",    32'(enablewrite), 32'd0);
      chk("t7_rst_stall", 32'(stall_count), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      set_sb(0, 0, 0, 0, 0, 0);

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         set_instr(($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0,
                   5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                   5'($urandom_range(7, 0)), 2'($urandom_range(3, 0)),
                   1'($urandom), 1'($urandom), 1'($urandom));
         set_sb(($urandom_range(9, 0) < 4) ? 1'b1 : 1'b0, 2'($urandom_range(3, 0)),
                ($urandom_range(2, 0) == 0) ? 5'b00001 : rand_row(),
                ($urandom_range(9, 0) < 4) ? 1'b1 : 1'b0, 2'($urandom_range(3, 0)),
                ($urandom_range(2, 0) == 0) ? 5'b00001 : rand_row());
         issue_ready = ($urandom_range(9, 0) < 8) ? 1'b1 : 1'b0;
         flush       = ($urandom_range(19, 0) == 0) ? 1'b1 : 1'b0;
         settle();
         advance();
      end
      flush = 1'b0;
      settle();
      chk("final_stall_sat", 32'(stall_count), 32'(m_stall));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_control.md
# issue_control

Issue-stage controller between decode and the functional units. Holds one decoded instruction and queries the register scoreboard for both source operands. It stalls on RAW hazards and on a busy non-pipelined divider, and forwards operands from the final execute stage when permitted. On issue it claims the destination register in the scoreboard.

## Interface
- `DIV_CYCLES`, 8: occupancy of unit 3 (divider) in cycles; legal range 2..31.
- `STALL_CNT_W`, 16: width of the stall performance counter.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decode offers an instruction.
- `in_ready` out 1: the hold register accepts the instruction this cycle.
- `in_rs`, `in_rt`, `in_rd` in 5 each: source A, source B and destination registers.
- `in_unit` in 2: target functional unit (0..3, where 3 is the divider).
- `in_uses_rs`, `in_uses_rt`, `in_writes_rd` in 1 each: operand and destination usage flags.
- `flush` in 1: discard the held instruction.
- `ass_addr_a`, `ass_addr_b` out 5 each: scoreboard query addresses.
- `ass_pending_a`, `ass_pending_b` in 1 each: scoreboard pending status.
- `ass_unit_a`, `ass_unit_b` in 2 each: producing unit of the pending register.
- `ass_row_a`, `ass_row_b` in 5 each: one-hot execution stage; bit 0 is the final stage.
- `writeaddr` out 5, `registerunit` out 2, `enablewrite` out 1: scoreboard claim port.
- `issue_valid` out 1, `issue_ready` in 1: handshake to the units.
- `issue_rs`, `issue_rt`, `issue_rd` out 5 each, `issue_unit` out 2: fields of the issued instruction.
- `issue_fwd_a`, `issue_fwd_b` out 3 each: operand source. Bit 2 = bypass, bits 1:0 = unit; 3'b000 = register file.
- `stall_count` out `STALL_CNT_W`: saturating count of stalled cycles.

## Operation
- Hold register: a single entry (`hold_valid` plus fields). `in_ready = ~hold_valid | fire`, where `fire = issue_valid & issue_ready`.
- Queries: `ass_addr_a = hold rs` and `ass_addr_b = hold rt`, both combinational.
- Operand A is hazard-free in either case:
  - `!uses_rs`, `rs==0` or `!ass_pending_a`: source is the register file.
  - Bypass-eligible (see Configuration): `issue_fwd_a = {1'b1, ass_unit_a}`.
- Any other use of operand A is a RAW hazard. Operand B follows the same rules.
- Structural hazard: `issue_unit==3` while `div_cnt != 0`.
- `issue_valid = hold_valid & ~flush & no RAW hazard & no structural hazard`.
- `enablewrite = fire & writes_rd & (rd != 0)`. On that cycle `writeaddr = rd` and `registerunit = unit`; both are zero when `enablewrite` is low.
- Divider counter:
  - `fire` with unit 3 loads `DIV_CYCLES-1`.
  - Otherwise a nonzero count decrements by 1 per cycle.
- `stall_count` increments in every cycle with `hold_valid & ~issue_valid & ~flush`. It saturates at all-ones.
- `flush`:
  - Clears `hold_valid` at the next edge.
  - Blocks acceptance that cycle: `in_ready` is forced to 0.
  - Leaves `div_cnt` and the scoreboard unchanged.

## Timing
- Reset values:
  - `hold_valid` = 0, `div_cnt` = 0, `stall_count` = 0.
  - `in_ready` = 1.
  - `issue_valid`, `enablewrite`, `writeaddr`, `registerunit`, all `issue_*` fields and `issue_fwd_*` = 0.
- Latency: an instruction accepted at edge N can issue in the cycle after edge N; earliest `fire` is at edge N+1.
- Throughput is one instruction per cycle: accept and fire may occur in the same cycle.
- The scoreboard claim lands at the same edge as `fire`. The scoreboard then reports the register as pending from the next cycle.
- A dependent instruction that immediately follows its producer stalls until the producer reaches row bit 0 (bypass enabled) or clears (bypass disabled).
- `issue_ready` low with no hazard: `issue_valid` stays high and the fields are stable; no scoreboard write occurs.
- Reset asserted mid-stall drops the held instruction; no claim is emitted.

## Configuration
- `ISSUE_BYPASS_EN` defined: a pending operand whose `ass_row == 5'b00001` is bypass-eligible and does not stall.
- `ISSUE_BYPASS_EN` undefined:
  - Every pending operand stalls.
  - `issue_fwd_a` and `issue_fwd_b` are tied to 3'b000.

## Test plan
- Reset, then `in_valid` with rs=1, rt=2, rd=3, unit=0 and the scoreboard idle, `issue_ready=1` -> `fire` one cycle after acceptance; `enablewrite=1`, `writeaddr=3`, `registerunit=0`.
- Scoreboard reports r5 pending with row=5'b10000; the held instruction reads r5 -> `issue_valid=0` for 4 cycles with `stall_count` incrementing to 4. With `ISSUE_BYPASS_EN`, issue occurs on the row=00001 cycle with `issue_fwd_a` = 3'b1uu, where uu is the producer unit. Without it, issue occurs one cycle later with fwd=000.
- Divider instruction issues, followed by a second unit-3 instruction and `DIV_CYCLES=8` -> the second instruction issues exactly 8 cycles after the first. A unit-0 instruction queued behind the first divider op issues the next cycle.
- rd=0 with `writes_rd=1`, and rs=0 with r0 shown pending -> no stall; `enablewrite=0`.
- `issue_ready=0` for 3 cycles with no hazard -> `issue_valid` held high, fields stable, no `enablewrite`, `in_ready=0`.
- `flush` in a stalled cycle while `in_valid=1` -> held instruction discarded, incoming instruction not accepted, `stall_count` unchanged; `hold_valid=0` at the next edge.
